// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets,
// STATUS bit positions and FSM state codes.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_FRM_ERR  = 3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: input synchronizer, start-bit qualification,
// mid-bit sampling and stop-bit check.
module uart_rx_fsm
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_i,
    input  logic [15:0] baud_div_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_data_o,
    output logic        frame_err_o
);

    logic        s1_q, s2_q, prev_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        fall;
    logic [15:0] half_div;

    assign fall        = prev_q & ~s2_q;
    assign half_div    = {1'b0, baud_div_i[15:1]};
    assign byte_data_o = shift_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = half_div - 16'd1;
                end
            end
            RX_START: begin
                if (cnt_q == 16'd0) begin
                    // A high mid-start sample is a line glitch
                    if (s2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = baud_div_i - 16'd1;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {s2_q, shift_q[7:1]};
                    cnt_d   = baud_div_i - 16'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d      = RX_IDLE;
                    byte_valid_o = s2_q;
                    frame_err_o  = ~s2_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register decode, transmit FSM and
// sticky status flags around the receive FSM.
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          BAUD_DIV_RST = 434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        sel_o,
    output logic        tx_o,
    input  logic        rx_i
);

    logic [1:0]  off;
    logic        wr_tx, wr_stat, wr_baud;
    logic [2:0]  clr;

    logic [15:0] baud_q, baud_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        frm_err_q, frm_err_d;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_busy, tx_fire;

    logic        rx_byte_valid, rx_frame_err;
    logic [7:0]  rx_byte;
    logic        unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

    assign sel_o   = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off     = addr_i[3:2];
    assign wr_tx   = we_i & sel_o & (off == REG_TXDATA);
    assign wr_stat = we_i & sel_o & (off == REG_STATUS);
    assign wr_baud = we_i & sel_o & (off == REG_BAUDDIV);
    assign clr     = wr_stat ? wdata_i[3:1] : 3'b000;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx_o    = tx_q;

    // The edge that ends STOP also accepts a new frame back-to-back
    assign tx_fire = wr_tx & (~tx_busy |
                     ((tx_state_q == TX_STOP) && (tx_cnt_q == 16'd0)));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        txdata_d   = txdata_q;
        case (tx_state_q)
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = baud_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = baud_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) tx_state_d = TX_IDLE;
                else                   tx_cnt_d   = tx_cnt_q - 16'd1;
            end
            default: ;
        endcase
        if (tx_fire) begin
            tx_state_d = TX_START;
            tx_cnt_d   = baud_q - 16'd1;
            tx_d       = 1'b0;
            tx_shift_d = wdata_i[7:0];
            txdata_d   = wdata_i[7:0];
        end
    end

    always_comb begin
        baud_d = baud_q;
        if (wr_baud) begin
            baud_d = (wdata_i[15:0] < MIN_BAUD_DIV) ? MIN_BAUD_DIV
                                                    : wdata_i[15:0];
        end
        rxdata_d   = rx_byte_valid ? rx_byte : rxdata_q;
        // Hardware set is ORed in after the clear so it wins
        rx_valid_d = (rx_valid_q & ~clr[0]) | rx_byte_valid;
        rx_ovr_d   = (rx_ovr_q & ~clr[1]) | (rx_byte_valid & rx_valid_q);
        frm_err_d  = (frm_err_q & ~clr[2]) | rx_frame_err;
    end

    always_comb begin
        rdata_o = '0;
        if (sel_o) begin
            case (off)
                REG_TXDATA:  rdata_o = {24'b0, txdata_q};
                REG_RXDATA:  rdata_o = {24'b0, rxdata_q};
                REG_STATUS:  rdata_o = {28'b0, frm_err_q, rx_ovr_q,
                                        rx_valid_q, tx_busy};
                REG_BAUDDIV: rdata_o = {16'b0, baud_q};
                default:     rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            baud_q     <= 16'(BAUD_DIV_RST);
            txdata_q   <= '0;
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            baud_q     <= baud_d;
            txdata_q   <= txdata_d;
            rxdata_q   <= rxdata_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            frm_err_q  <= frm_err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    uart_rx_fsm u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rx_i         (rx_i),
        .baud_div_i   (baud_q),
        .byte_valid_o (rx_byte_valid),
        .byte_data_o  (rx_byte),
        .frame_err_o  (rx_frame_err)
    );

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with a frame-timing model checked
// every cycle plus literal spot checks.
module tb_uart_mmio;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_BD = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = A_ST;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        sel_o;
    logic        tx_o;
    logic        rx_i = 1'b1;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;
    bit rx_quiet = 1'b1;

    logic [7:0]  m_txdata = '0;
    logic [7:0]  m_rxdata = '0;
    logic [15:0] m_baud = 16'd434;
    logic [2:0]  m_flags = '0;
    bit          tx_active = 1'b0;
    int          tx_start = 0;
    int          tx_b = 4;

    uart_mmio #(.BASE_ADDR(BASE), .BAUD_DIV_RST(434)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .sel_o   (sel_o),
        .tx_o    (tx_o),
        .rx_i    (rx_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    function automatic logic hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic exp_busy();
        return tx_active && ((cyc - tx_start) < 10 * tx_b);
    endfunction

    // Line level from elapsed time: start bit, 8 data bits, stop bit
    function automatic logic exp_tx();
        int d, k;
        if (!exp_busy()) return 1'b1;
        d = cyc - tx_start;
        k = d / tx_b;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_txdata[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx_o", {31'b0, tx_o}, {31'b0, exp_tx()});
            chk("sel_o", {31'b0, sel_o}, {31'b0, hit(addr_i)});
            if (!hit(addr_i)) begin
                chk("rdata_unmapped", rdata_o, 32'h0);
            end else begin
                case (addr_i[3:2])
                    2'd0: chk("txdata", rdata_o, {24'b0, m_txdata});
                    2'd1: if (rx_quiet)
                        chk("rxdata", rdata_o, {24'b0, m_rxdata});
                    2'd2: begin
                        chk("tx_busy", {31'b0, rdata_o[0]},
                            {31'b0, exp_busy()});
                        if (rx_quiet)
                            chk("rx_flags", {29'b0, rdata_o[3:1]},
                                {29'b0, m_flags});
                    end
                    default: chk("bauddiv", rdata_o, {16'b0, m_baud});
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = rdata_o;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        step();
        we_i = 1'b0;
        if (hit(a)) begin
            case (a[3:2])
                2'd0: if (!exp_busy()) begin
                    tx_active = 1'b1;
                    tx_start  = cyc;
                    tx_b      = int'(m_baud);
                    m_txdata  = d[7:0];
                end
                2'd2: m_flags = m_flags & ~d[3:1];
                2'd3: m_baud = (d[15:0] < 16'd4) ? 16'd4 : d[15:0];
                default: ;
            endcase
        end
        addr_i = A_ST;
    endtask

    task automatic model_reset();
        tx_active = 1'b0;
        m_txdata  = '0;
        m_rxdata  = '0;
        m_baud    = 16'd434;
        m_flags   = '0;
    endtask

    // Frame at 4 clocks per bit
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_quiet = 1'b0;
        rx_i = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (4) step();
        end
        rx_i = stop;
        repeat (4) step();
        rx_i = 1'b1;
        repeat (8) step();
        if (stop) begin
            m_flags[1] = m_flags[1] | m_flags[0];
            m_flags[0] = 1'b1;
            m_rxdata   = b;
        end else begin
            m_flags[2] = 1'b1;
        end
        rx_quiet = 1'b1;
    endtask

    logic [31:0] v;
    int e;

    initial begin
        repeat (3) step();
        chk("rst_tx_o", {31'b0, tx_o}, 32'd1);
        rd(A_ST, v); chk("rst_status", v, 32'h0);
        rd(A_BD, v); chk("rst_bauddiv", v, 32'd434);
        rd(A_RX, v); chk("rst_rxdata", v, 32'h0);
        rd(32'h0000_2000, v); chk("unmapped_rdata", v, 32'h0);
        chk("unmapped_sel", {31'b0, sel_o}, 32'h0);
        reset_i = 1'b1;
        addr_i  = A_ST;
        chk_on  = 1'b1;
        step();

        wr(A_BD, 32'd1);
        rd(A_BD, v); chk("baud_clamp", v, 32'd4);
        wr(A_BD, 32'd4);

        wr(A_TX, 32'h55);
        e = cyc;
        wait_cyc(e + 5);
        chk("tx_bit0", {31'b0, tx_o}, 32'd1);
        wait_cyc(e + 9);
        chk("tx_bit1", {31'b0, tx_o}, 32'd0);
        wait_cyc(e + 11);
        wr(A_TX, 32'hAA);
        rd(A_TX, v); chk("tx_drop", v, 32'h55);
        wait_cyc(e + 39);
        rd(A_ST, v); chk("busy_end", v, 32'h1);
        wr(A_TX, 32'hAA);
        chk("b2b_start", {31'b0, tx_o}, 32'd0);
        rd(A_TX, v); chk("b2b_txdata", v, 32'hAA);
        repeat (45) step();
        rd(A_ST, v); chk("tx_done", v, 32'h0);

        rx_frame(8'hA5, 1'b1);
        rd(A_RX, v); chk("rx_a5", v, 32'hA5);
        rd(A_ST, v); chk("rx_valid", v, 32'h2);
        rx_frame(8'h3C, 1'b1);
        rd(A_RX, v); chk("rx_3c", v, 32'h3C);
        rd(A_ST, v); chk("rx_overrun", v, 32'h6);
        wr(A_ST, 32'h6);
        rd(A_ST, v); chk("w1c", v, 32'h0);

        rx_i = 1'b0;
        step();
        rx_i = 1'b1;
        repeat (12) step();
        rd(A_ST, v); chk("glitch", v, 32'h0);
        rx_frame(8'hF0, 1'b0);
        rd(A_ST, v); chk("frame_err", v, 32'h8);
        rd(A_RX, v); chk("ferr_rxdata", v, 32'h3C);
        wr(A_ST, 32'h8);

        wr(A_TX, 32'h33);
        e = cyc;
        wait_cyc(e + 15);
        reset_i = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_tx", {31'b0, tx_o}, 32'd1);
        rd(A_ST, v); chk("rst_mid_busy", v, 32'h0);
        repeat (3) step();
        reset_i = 1'b1;
        wr(A_BD, 32'd4);
        wr(A_TX, 32'h01);
        e = cyc;
        wait_cyc(e + 5);
        chk("post_rst_bit0", {31'b0, tx_o}, 32'd1);
        repeat (45) step();
        rd(A_TX, v); chk("post_rst_tx", v, 32'h01);
        step();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
